// File: rtl/input_pio_debounce.sv
// input_pio_debounce: debounced Avalon-MM input PIO with edge capture and level interrupt
//
// Parameters:
//   WIDTH           number of input bits (1..32)
//   DEBOUNCE_CYCLES stable synchronised cycles before a bit is accepted (>=1)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_port    raw asynchronous inputs
//   address    word offset: 0 DATA (RO), 1 MASK (RW), 2 EDGE (W1C), 3 POL (RW, 1 = rising)
//   read       read strobe, readdata valid one cycle later
//   write      write strobe
//   writedata  write data, bits above WIDTH ignored
//   readdata   registered read data, upper bits zero
//   irq        registered OR of EDGE & MASK
//
// Build option: define INPUT_PIO_DEBOUNCE_DEBOUNCE_EN to build the per-bit debounce
// counters; without it the debounced bit is the synchroniser output.
module input_pio_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] s1, s2, deb, deb_d, mask, edges, pol, hit, clr;
    logic unused_bits;

    assign unused_bits = ^{writedata, DEBOUNCE_CYCLES};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end

`ifdef INPUT_PIO_DEBOUNCE_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt [WIDTH];

    // The counter runs only while the synchronised bit disagrees with the accepted
    // value; the edge where it would reach DEBOUNCE_CYCLES accepts the new value.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            deb <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (s2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + CW'(1);
        end
`else
    assign deb = s2;
`endif

    // A new qualifying edge takes priority over a simultaneous write-1-to-clear.
    always_comb begin
        hit = (pol & deb & ~deb_d) | (~pol & ~deb & deb_d);
        clr = (write && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            deb_d    <= '0;
            mask     <= '0;
            edges    <= '0;
            pol      <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            deb_d <= deb;
            edges <= (edges & ~clr) | hit;
            irq   <= |(edges & mask);
            if (write && address == 2'd1) mask <= writedata[WIDTH-1:0];
            if (write && address == 2'd3) pol <= writedata[WIDTH-1:0];
            if (read)
                readdata <= address == 2'd0 ? 32'(deb) :
                            address == 2'd1 ? 32'(mask) :
                            address == 2'd2 ? 32'(edges) : 32'(pol);
        end
endmodule

// File: tb/tb_input_pio_debounce.sv
// tb_input_pio_debounce: self-checking bench for input_pio_debounce (WIDTH=4, DEBOUNCE_CYCLES=4)
module tb_input_pio_debounce;
    localparam int WIDTH = 4;
    localparam int DC    = 4;
`ifdef INPUT_PIO_DEBOUNCE_DEBOUNCE_EN
    localparam int LAT = 2 + DC;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in_port = '0;
    logic [1:0]       address = '0;
    logic             read = 1'b0;
    logic             write = 1'b0;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic             irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];
    logic [31:0] got, exp;

    input_pio_debounce #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .in_port(in_port), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        in_port = '0;
        read = 1'b0;
        write = 1'b0;
        address = '0;
        writedata = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read = 1'b1;
        tick();
        read = 1'b0;
        d = readdata;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got readdata=%h irq=%b want 0 0", readdata, irq);
        end
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            exp_q.push_back(32'h0);
            rd(a[1:0], got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h want %h", a, got, exp);
            end
        end
    endtask

    task automatic test_step;
        do_reset();
        wr(2'd3, 32'h1);
        wr(2'd1, 32'h1);
        read = 1'b1;
        address = 2'd0;
        in_port = 4'h1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            if (k == LAT || k == LAT + 1) begin
                exp = exp_q.pop_front();
                checks++;
                if (readdata !== exp) begin
                    errors++;
                    $display("FAIL step_data_edge%0d: got %h want %h", k, readdata, exp);
                end
            end
            if (k == LAT + 1 || k == LAT + 2) begin
                checks++;
                if (irq !== (k == LAT + 2)) begin
                    errors++;
                    $display("FAIL step_irq_edge%0d: got %b want %b", k, irq, k == LAT + 2);
                end
            end
        end
        read = 1'b0;
        exp_q.push_back(32'h1);
        rd(2'd2, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL step_edge: got %h want %h", got, exp);
        end
    endtask

    task automatic test_glitch;
        do_reset();
        wr(2'd3, 32'hF);
        wr(2'd1, 32'hF);
        in_port = 4'h2;
        repeat (3) tick();
        in_port = 4'h0;
        repeat (12) tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL glitch_irq: got %b want 0", irq);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        rd(2'd0, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL glitch_data: got %h want %h", got, exp);
        end
        rd(2'd2, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL glitch_edge: got %h want %h", got, exp);
        end
        in_port = 4'h2;
        exp_q.push_back(32'h2);
        repeat (4) tick();
        in_port = 4'h0;
        repeat (12) tick();
        rd(2'd2, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL glitch_min_pulse_edge: got %h want %h", got, exp);
        end
    endtask

    task automatic test_fall_irq;
        do_reset();
        wr(2'd1, 32'h4);
        in_port = 4'h4;
        repeat (LAT + 3) tick();
        exp_q.push_back(32'h0);
        rd(2'd2, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || irq !== 1'b0) begin
            errors++;
            $display("FAIL fall_rise_ignored: got edge=%h irq=%b want %h 0", got, irq, exp);
        end
        in_port = 4'h0;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            if (k >= LAT + 1) begin
                checks++;
                if (irq !== (k == LAT + 2)) begin
                    errors++;
                    $display("FAIL fall_irq_edge%0d: got %b want %b", k, irq, k == LAT + 2);
                end
            end
        end
        exp_q.push_back(32'h4);
        rd(2'd2, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL fall_edge: got %h want %h", got, exp);
        end
        wr(2'd2, 32'h4);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL fall_irq_hold: got %b want 1", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL fall_irq_clear: got %b want 0", irq);
        end
        exp_q.push_back(32'h0);
        rd(2'd2, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL fall_edge_clear: got %h want %h", got, exp);
        end
    endtask

    task automatic test_w1c_collide;
        do_reset();
        wr(2'd3, 32'h8);
        in_port = 4'h8;
        repeat (LAT) tick();
        address = 2'd2;
        writedata = 32'h8;
        write = 1'b1;
        tick();
        write = 1'b0;
        exp_q.push_back(32'h8);
        rd(2'd2, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL w1c_collide: got %h want %h", got, exp);
        end
        wr(2'd2, 32'h8);
        exp_q.push_back(32'h0);
        rd(2'd2, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL w1c_plain: got %h want %h", got, exp);
        end
    endtask

    task automatic test_regs;
        do_reset();
        wr(2'd1, 32'hFFFF_FFF5);
        exp_q.push_back(32'h5);
        rd(2'd1, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL regs_mask_upper: got %h want %h", got, exp);
        end
        wr(2'd3, 32'h6);
        exp_q.push_back(32'h6);
        rd(2'd3, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL regs_pol: got %h want %h", got, exp);
        end
        wr(2'd0, 32'hF);
        exp_q.push_back(32'h0);
        rd(2'd0, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL regs_data_ro: got %h want %h", got, exp);
        end
        address = 2'd1;
        writedata = 32'hA;
        read = 1'b1;
        write = 1'b1;
        exp_q.push_back(32'h5);
        tick();
        read = 1'b0;
        write = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (readdata !== exp) begin
            errors++;
            $display("FAIL regs_rw_same: got %h want %h", readdata, exp);
        end
        exp_q.push_back(32'hA);
        rd(2'd1, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL regs_mask_after: got %h want %h", got, exp);
        end
        wr(2'd1, 32'h3);
        tick();
        tick();
        checks++;
        if (readdata !== 32'hA) begin
            errors++;
            $display("FAIL regs_hold: got %h want %h", readdata, 32'hA);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        wr(2'd1, 32'hF);
        wr(2'd3, 32'hF);
        rd(2'd1, got);
        in_port = 4'h1;
        repeat (5) tick();
        reset = 1'b1;
        in_port = 4'hF;
        #1;
        checks++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: got readdata=%h irq=%b want 0 0", readdata, irq);
        end
        tick();
        tick();
        reset = 1'b0;
        read = 1'b1;
        address = 2'd0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hF);
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            if (k >= LAT) begin
                exp = exp_q.pop_front();
                checks++;
                if (readdata !== exp) begin
                    errors++;
                    $display("FAIL mid_reset_data_edge%0d: got %h want %h", k, readdata, exp);
                end
            end
        end
        read = 1'b0;
        for (int a = 1; a < 4; a++) begin
            exp_q.push_back(32'h0);
            rd(a[1:0], got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_reset_reg%0d: got %h want %h", a, got, exp);
            end
        end
    endtask

    task automatic test_nodebounce;
        do_reset();
        read = 1'b1;
        address = 2'd0;
        in_port = 4'hA;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hA);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k >= 2) begin
                exp = exp_q.pop_front();
                checks++;
                if (readdata !== exp) begin
                    errors++;
                    $display("FAIL nodebounce_edge%0d: got %h want %h", k, readdata, exp);
                end
            end
        end
        read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_fall_irq();
        test_w1c_collide();
        test_regs();
`ifdef INPUT_PIO_DEBOUNCE_DEBOUNCE_EN
        test_glitch();
        test_reset_mid();
`else
        test_nodebounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/input_pio_debounce.md
INPUT_PIO_DEBOUNCE -- requirements
Module: input_pio_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of input bits (legal 1..32).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the stable-cycle count before a bit is accepted (legal >=1).
REQ-003 Port clk, input, 1 bit: the single clock; all logic is rising-edge on clk.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port in_port, input, WIDTH bits: raw asynchronous button/switch inputs.
REQ-006 Port address, input, 2 bits: Avalon-MM word offset.
REQ-007 Port read, input, 1 bit: Avalon-MM read strobe.
REQ-008 Port write, input, 1 bit: Avalon-MM write strobe.
REQ-009 Port writedata, input, 32 bits: write data.
REQ-010 Port readdata, output, 32 bits: read data.
REQ-011 Port irq, output, 1 bit: level interrupt, active-high.

Function
REQ-012 Each in_port bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-013 Each bit SHALL have its own debounce counter; it clears when synchronised bit equals debounced bit and increments otherwise.
REQ-014 The debounced bit SHALL take the synchronised value on the clock edge where the counter reaches DEBOUNCE_CYCLES, and the counter SHALL clear on that edge.
REQ-015 Raw-to-debounced latency SHALL be exactly 2 + DEBOUNCE_CYCLES edges for a clean step; any glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL NOT change the debounced bit.
REQ-016 Register map (word offsets): 0 DATA, debounced bits, read-only, writes ignored; 1 MASK, irq enable per bit, R/W; 2 EDGE, captured edges, write-1-to-clear; 3 POL, per-bit edge select, 1 = rising, 0 = falling, R/W.
REQ-017 An EDGE bit SHALL set on the edge after a debounced transition matching its POL bit, and SHALL remain set until cleared.
REQ-018 If a write-1-to-clear and a new qualifying edge hit the same EDGE bit on the same cycle, the bit SHALL remain set.
REQ-019 irq SHALL be a registered OR of (EDGE & MASK), updating one cycle after either register changes.
REQ-020 readdata SHALL be registered with read latency 1, SHALL update only on cycles with read asserted, and SHALL otherwise hold its value.
REQ-021 readdata bits [31:WIDTH] SHALL read 0, and writedata bits [31:WIDTH] SHALL be ignored.
REQ-022 Simultaneous read and write to the same offset SHALL return the pre-write value.

Reset
REQ-023 Reset SHALL clear the synchronisers, debounced bits, counters, MASK, EDGE, POL, readdata and irq to 0, with immediate (asynchronous) effect.
REQ-024 Reset asserted mid-debounce SHALL discard progress; after release, an input held high SHALL produce a debounced rising transition 2 + DEBOUNCE_CYCLES edges later.

Configuration
REQ-025 With macro INPUT_PIO_DEBOUNCE_DEBOUNCE_EN defined, debounce counters SHALL be built as in REQ-013..015.
REQ-026 With INPUT_PIO_DEBOUNCE_DEBOUNCE_EN undefined, no counters SHALL be built, the debounced bit SHALL equal the synchroniser output (latency 2 edges), and DEBOUNCE_CYCLES SHALL be ignored.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-027 Step in_port[0] 0->1 and hold -> DATA bit0 = 1 exactly 6 edges later; with POL[0]=1, EDGE[0]=1 one edge after that.
REQ-028 Pulse in_port[1] high for 3 cycles -> DATA stays 0x0, EDGE stays 0x0, irq stays 0.
REQ-029 MASK=0x4, POL=0x0, in_port[2] falls after being debounced high -> EDGE=0x4, irq=1 one edge later; write EDGE=0x4 -> EDGE=0x0 and irq=0 one edge later.
REQ-030 Write-1-to-clear EDGE[3] on the same cycle as a new qualifying edge on bit 3 -> EDGE[3] stays 1.
REQ-031 Assert reset while a counter is at 3 -> all registers read 0 and irq=0; after release, in_port=0xF held -> DATA=0xF after 6 edges.
REQ-032 Macro undefined, step in_port=0xA -> DATA=0xA exactly 2 edges later.
